// File: rtl/riscv_mpsoc_pkg.sv
// Shared definitions for the MPSoC integer datapath: multiplier function codes
// and the latency range supported by the shared multiplier.
package riscv_mpsoc_pkg;

    typedef enum logic [2:0] {
        MULF_MUL    = 3'd0,
        MULF_MULH   = 3'd1,
        MULF_MULHSU = 3'd2,
        MULF_MULHU  = 3'd3,
        MULF_MULW   = 3'd4
    } mul_func_e;

    localparam int unsigned MUL_LAT_MIN = 1;
    localparam int unsigned MUL_LAT_MAX = 3;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr;
// the pointer moves past the winner when advance is high.
module riscv_rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] rr_ptr_q, rr_ptr_d;
    logic         found;
    int unsigned  idx;

    always_comb begin
        gnt      = '0;
        found    = 1'b0;
        idx      = 0;
        rr_ptr_d = rr_ptr_q;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx[W-1:0]]) begin
                found            = 1'b1;
                gnt[idx[W-1:0]]  = 1'b1;
                if (advance) rr_ptr_d = (idx == N - 1) ? '0 : W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/riscv_mul_sched.sv
// Shares one fixed-latency pipelined multiplier between NREQ requesters:
// round-robin issue, owner-tag pipeline and per-requester response registers.
module riscv_mul_sched
    import riscv_mpsoc_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_opA,
    input  logic [NREQ*XLEN-1:0] req_opB,
    input  logic [NREQ*3-1:0]    req_func,
    input  logic [NREQ-1:0]      req_kill,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*XLEN-1:0] rsp_r,
    output logic                 mul_in_valid,
    output logic [XLEN-1:0]      mul_opA,
    output logic [XLEN-1:0]      mul_opB,
    output logic [2:0]           mul_func,
    input  logic [XLEN-1:0]      mul_out_r
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (LATENCY < MUL_LAT_MIN || LATENCY > MUL_LAT_MAX) begin : g_bad_latency
        $error("riscv_mul_sched: LATENCY outside supported multiplier range");
    end

    logic [NREQ-1:0]      busy_q, busy_d;
    logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [NREQ*XLEN-1:0] rsp_r_q, rsp_r_d;
    logic [LATENCY-1:0]   tag_v_q, tag_v_d;
    logic [IDXW-1:0]      tag_o_q [LATENCY];
    logic [IDXW-1:0]      tag_o_d [LATENCY];
    logic [NREQ-1:0]      elig, gnt;
    logic [IDXW-1:0]      gnt_idx, wb_own;
    logic                 wb_en;

    // Grants are suppressed during reset so nothing issues from stale busy state.
    assign elig = rst ? '0 : (req_valid & ~busy_q & ~req_kill);

    riscv_rr_arbiter #(.N(NREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .advance (|elig),
        .gnt     (gnt)
    );

    assign req_ready    = gnt;
    assign mul_in_valid = |gnt;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_r        = rsp_r_q;

    always_comb begin
        mul_opA  = '0;
        mul_opB  = '0;
        mul_func = '0;
        gnt_idx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mul_opA  = req_opA[i*XLEN +: XLEN];
                mul_opB  = req_opB[i*XLEN +: XLEN];
                mul_func = req_func[i*3 +: 3];
                gnt_idx  = IDXW'(i);
            end
        end
    end

    // A kill invalidates the owner's tags as they shift, and blocks writeback at the last stage.
    always_comb begin
        wb_own     = tag_o_q[LATENCY-1];
        wb_en      = tag_v_q[LATENCY-1] && !req_kill[wb_own];
        tag_v_d    = '0;
        tag_v_d[0] = |gnt;
        tag_o_d[0] = gnt_idx;
        for (int unsigned s = 1; s < LATENCY; s++) begin
            tag_v_d[s] = tag_v_q[s-1] && !req_kill[tag_o_q[s-1]];
            tag_o_d[s] = tag_o_q[s-1];
        end
    end

    always_comb begin
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_r_d     = rsp_r_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (rsp_valid_q[i] && rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
                busy_d[i]      = 1'b0;
            end
            if (wb_en && wb_own == IDXW'(i)) begin
                rsp_valid_d[i]            = 1'b1;
                rsp_r_d[i*XLEN +: XLEN]   = mul_out_r;
            end
            if (gnt[i]) busy_d[i] = 1'b1;
            if (req_kill[i]) begin
                busy_d[i]      = 1'b0;
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_r_q     <= '0;
            tag_v_q     <= '0;
        end else begin
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            tag_v_q     <= tag_v_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_o_q <= tag_o_d;
    end

endmodule

// File: doc/riscv_mul_sched.md
# riscv_mul_sched

Scheduler that shares one fixed-latency, non-stallable pipelined multiplier between `NREQ` requesters, such as integer pipelines of several harts or an integer pipe plus a CSR/debug unit. It arbitrates requests round-robin, issues operands and function code to the multiplier, and tracks ownership of every in-flight operation through a tag pipeline. It also holds each result in a per-requester response register until the owner accepts it. The block sits between the execute-stage requesters and the shared multiplier datapath.

## Interface
- `XLEN`, 64, operand/result width
- `NREQ`, 2, number of requesters (2..8)
- `LATENCY`, 2, multiplier latency in cycles from `mul_in_valid` to `mul_out_r` valid (1..3)
- `clk`  in  1  clock; one clock domain
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  NREQ  per-requester request
- `req_ready`  out  NREQ  per-requester accept (grant)
- `req_opA`, `req_opB`  in  NREQ*XLEN  operands, requester i at slice [i*XLEN +: XLEN]
- `req_func`  in  NREQ*3  mul function code (package enum), slice [i*3 +: 3]
- `req_kill`  in  NREQ  flush: discard requester i's pending/in-flight op and response
- `rsp_valid`  out  NREQ  result held for requester i
- `rsp_ready`  in  NREQ  requester i consumes result
- `rsp_r`  out  NREQ*XLEN  result, slice [i*XLEN +: XLEN]
- `mul_in_valid`  out  1  issue to multiplier
- `mul_opA`, `mul_opB`  out  XLEN  issued operands
- `mul_func`  out  3  issued function code
- `mul_out_r`  in  XLEN  multiplier result, valid exactly LATENCY cycles after issue

## Operation
- `busy[i]` is set on accept (`req_valid[i] && req_ready[i]`). It clears on response handshake (`rsp_valid[i] && rsp_ready[i]`) or on `req_kill[i]`. Each requester has at most one op outstanding.
- Eligibility: `elig[i] = req_valid[i] && !busy[i] && !req_kill[i]`.
- Round-robin: grant goes to the first eligible index at or after `rr_ptr`, cyclically. At most one grant per cycle. After a grant to i, `rr_ptr <= (i+1) mod NREQ`. If there is no grant, `rr_ptr` holds.
- `req_ready` is combinational from `req_valid`. Requesters shall not make `req_valid` depend on `req_ready`.
- Issue happens in the grant cycle. `mul_in_valid = |grant`, and `mul_opA`, `mul_opB`, `mul_func` are muxed from the granted requester. When idle these outputs are don't-care; the bench checks them only while `mul_in_valid` is high.
- Tag pipeline: LATENCY stages of {valid, owner[$clog2(NREQ)-1:0]}. Stage 0 is loaded on issue; the last stage aligns with `mul_out_r`.
- Kill: `req_kill[i]` clears the valid bit of every tag stage owned by i and clears `rsp_valid[i]`. A result whose tag is invalid is dropped.
- Writeback: when the last tag stage is valid with owner k and k is not killed this cycle, the block sets `rsp_r[k] <= mul_out_r` and `rsp_valid[k] <= 1`.
- `rsp_valid[k]` holds and `rsp_r[k]` stays stable until handshake or kill.
- Simultaneous events:
  - Kill and accept from the same requester: kill wins and `req_ready` is 0.
  - Kill and result arrival for the same requester: the result is dropped.
  - Response handshake and a new request from the same requester: the request is not accepted that cycle, because `busy` is still set. It is accepted the next cycle at the earliest.
- Reset (any cycle, including mid-operation):
  - `rr_ptr=0`, all tag valids 0, `busy=0`, `rsp_valid=0`, `rsp_r=0`.
  - Combinational outputs follow from this state.
  - Results in flight at reset are dropped.

## Timing
- Accept at cycle T: `mul_in_valid=1` at T. `mul_out_r` is sampled at T+LATENCY. `rsp_valid` rises at T+LATENCY+1.
- Same-requester back-to-back: earliest next accept is the cycle after its response handshake. With `rsp_ready` tied high, one op per LATENCY+2 cycles per requester.
- Aggregate: one issue per cycle when at least LATENCY+2 requesters are eligible. The multiplier never stalls and no result is lost, because each owner has a reserved response register.
- Fairness: a continuously eligible requester is granted within NREQ cycles.

## Structure
- Shared package `riscv_mpsoc_pkg`:
  - mul function enum `MULF_MUL=0, MULF_MULH=1, MULF_MULHSU=2, MULF_MULHU=3, MULF_MULW=4`.
  - Legal range of `LATENCY`, matching the multiplier's latency setting.
- Sub-module `riscv_rr_arbiter` (parameter `N`): inputs `clk`, `rst`, `req[N]`, `advance`; output one-hot `gnt[N]`. It contains `rr_ptr`.
- The top level contains the busy flags, tag pipeline, response registers and issue mux.

## Test plan
- Single op: NREQ=2, LATENCY=2. Requester 0 issues opA=7, opB=6, MULF_MUL at T.
  - Required: `mul_in_valid` at T; model drives 42 at T+2; `rsp_valid[0]=1`, `rsp_r[0]=42` at T+3. No `rsp_valid[1]`.
- Round-robin: both requesters valid continuously with `rsp_ready=1`.
  - Required: grants 0,1 then wait. Grant sequence alternates 0,1,0,1. No requester is granted twice in a row while the other is eligible.
- Backpressure: `rsp_ready[1]=0` for 10 cycles after the result.
  - Required: `rsp_r[1]` is stable and `req_ready[1]=0` throughout. Requester 0 continues to be served.
  - After `rsp_ready[1]=1`, the handshake occurs and a new accept for requester 1 is possible the next cycle.
- Kill in flight: requester 0 accepted at T, `req_kill[0]` at T+1.
  - Required: no `rsp_valid[0]` ever. `busy[0]` is clear, so `req_ready[0]=1` at T+2 when valid.
  - A requester 1 op issued at T+1 completes normally at T+4.
- Kill/accept collision: `req_valid[0]` and `req_kill[0]` in the same cycle.
  - Required: `req_ready[0]=0` and `mul_in_valid=0` (no other requester valid).
- Reset mid-flight: assert `rst` at T+1 after an accept at T.
  - Required: `rsp_valid=0` and `mul_in_valid=0` during reset. Nothing is delivered after reset. The first post-reset grant goes to requester 0.
